sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised successor to the single-player pixel merge. Composites NUM_CH sprite channels over a background layer into one PIX_W-bit palette index for the frame buffer.
- Adds several features absent today:
  - fixed priority across channels
  - transparency key
  - per-channel blink driven by an internal frame counter
  - per-frame collision flags between channel 0 (player) and every other channel
- Sits between the sprite generators (player, enemies, bullets) and the frame buffer / colour mapper.

Parameters:
- NUM_CH, 4: number of sprite channels; channel 0 = player, highest priority. Legal range 2..8.
- PIX_W, 5: palette index width.
- TRANSPARENT, 0: palette index treated as see-through.
- BLINK_BIT, 3: frame_count bit gating blink; blink period = 2^(BLINK_BIT+1) frames.
- FC_W, 7: frame counter width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- pix_en  in  1  one-cycle pixel strobe; all pipeline, counter and collision state advance only when it is 1.
- blank_n  in  1  1 = active video region.
- vs_n  in  1  vertical sync, active low.
- ch_on  in  NUM_CH  channel i covers the current pixel.
- ch_pixel  in  NUM_CH*PIX_W  channel i index at [i*PIX_W +: PIX_W].
- ch_blink  in  NUM_CH  channel i is in blink mode.
- bg_pixel  in  PIX_W  background index.
- pixel_out  out  PIX_W  composited index.
- pixel_valid  out  1  pixel_out corresponds to an active-video pixel.
- collide  out  NUM_CH  latched collisions of the previous frame; bit 0 is always 0.
- frame_count  out  FC_W  completed-frame counter.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1; overrides pix_en): every output and all internal state go to 0: pipeline registers, collision accumulator, vs_n history register (reset to 1). Reset mid-frame discards partial collision data.
- Opacity rule, per channel i, evaluated in stage 1: opaque_i = ch_on[i] & (ch_pixel_i != TRANSPARENT) & ~(ch_blink[i] & frame_count[BLINK_BIT]).
- Stage 1 (pix_en beat n): register opaque vector, all channel indices, bg_pixel and blank_n.
- Stage 2 (beat n+1): pixel_out = index of the lowest-numbered opaque channel, else bg_pixel. If the stage-1 blank_n was 0, pixel_out = 0 and pixel_valid = 0; otherwise pixel_valid = 1.
- Latency: exactly 2 pix_en beats from input to pixel_out / pixel_valid. Outputs hold between strobes.
- Collision accumulator acc[NUM_CH-1:1], updated in stage 2: acc[i] |= opaque_0 & opaque_i & blank_n (stage-1 values). Transparent or blanked pixels never collide.
- Frame edge: a pix_en beat where vs_n is 0 and its previous sampled value was 1 (falling edge).
  - On that beat: collide <= {acc | this beat's hits, 1'b0}; acc <= 0; frame_count <= frame_count + 1.
  - frame_count wraps modulo 2^FC_W.
  - A hit in the same beat as the edge belongs to the ending frame.
- Between frame edges, collide is stable. Consumers sample it any time.
- pix_en = 0: no state changes anywhere, including the vs_n edge detector.
- Arithmetic: priority encoder is combinational in stage 2; no adders except frame_count.

Decomposition:
- Shared package sprite_pkg:
  - PIX_W and TRANSPARENT defaults
  - typedef pix_t (logic [PIX_W-1:0])
  - channel index constants CH_PLAYER=0, CH_ENEMY=1, CH_BULLET=2, CH_ITEM=3
- One natural sub-module, frame_edge_counter: vs_n falling-edge detect plus frame_count register. It supersedes the standalone frame counter.
- Priority mux and collision logic stay inline.

Test Plan:
1. Reset, then ch_on=0, bg_pixel=5'd9, blank_n=1 for 3 strobes: pixel_out=9, pixel_valid=1 from the 2nd strobe after inputs apply; collide=0, frame_count=0.
2. ch_on=4'b0110, ch_pixel1=7, ch_pixel2=12: pixel_out=7. Then ch_pixel1=0 (transparent): pixel_out=12 two strobes later.
3. ch_on=4'b0101, ch_pixel0=3, ch_pixel2=4 for one active pixel, then a vs_n falling edge: collide=4'b0100, frame_count=1. Next frame with no overlap, then edge: collide=0, frame_count=2.
4. Overlap driven only while blank_n=0: pixel_out=0, pixel_valid=0, collide stays 0 after the edge.
5. ch_blink[1]=1, ch_on[1]=1, ch_pixel1=6, BLINK_BIT=3:
   - frames 0-7: output 6
   - frames 8-15: bg_pixel
   - 128 edges: frame_count wraps to 0.
6. Overlap hit on the same strobe as the vs_n edge: reported in the collide just latched. Reset asserted mid-frame after a hit: next edge latches collide=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: palette index defaults
// and the channel index assignments used by the sprite generators.
package sprite_pkg;

  localparam int DEFAULT_PIX_W = 5;
  localparam logic [DEFAULT_PIX_W-1:0] DEFAULT_TRANSPARENT = '0;

  typedef logic [DEFAULT_PIX_W-1:0] pix_t;

  localparam int CH_PLAYER = 0;
  localparam int CH_ENEMY  = 1;
  localparam int CH_BULLET = 2;
  localparam int CH_ITEM   = 3;

endpackage

// File: rtl/sprite_compositor_frame_edge_counter.sv
// Detects the vs_n falling edge on pixel strobes and counts completed frames.
module frame_edge_counter #(
  parameter int FC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            pix_en,
  input  logic            vs_n,
  output logic            frame_edge,
  output logic [FC_W-1:0] frame_count
);

  logic vs_prev;

  // The history only advances on strobes, so gaps between strobes never fake an edge.
  assign frame_edge = pix_en & ~vs_n & vs_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_prev     <= 1'b1;
      frame_count <= '0;
    end else if (pix_en) begin
      vs_prev <= vs_n;
      if (frame_edge) frame_count <= frame_count + FC_W'(1);
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: fixed-priority channel merge over the background,
// transparency key, frame-counter blink and per-frame player collision flags.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter logic [PIX_W-1:0] TRANSPARENT = DEFAULT_TRANSPARENT,
  parameter int BLINK_BIT = 3,
  parameter int FC_W      = 7
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_en,
  input  logic                    blank_n,
  input  logic                    vs_n,
  input  logic [NUM_CH-1:0]       ch_on,
  input  logic [NUM_CH*PIX_W-1:0] ch_pixel,
  input  logic [NUM_CH-1:0]       ch_blink,
  input  logic [PIX_W-1:0]        bg_pixel,
  output logic [PIX_W-1:0]        pixel_out,
  output logic                    pixel_valid,
  output logic [NUM_CH-1:0]       collide,
  output logic [FC_W-1:0]         frame_count
);

  // Flow control: pix_en is a one-cycle strobe with no back-pressure; every
  // register below moves exactly once per strobe and holds otherwise.

  logic                    frame_edge;
  logic [NUM_CH-1:0]       opaque;
  logic [NUM_CH-1:0]       s1_opaque;
  logic [NUM_CH*PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0]        s1_bg;
  logic                    s1_blank_n;
  logic [PIX_W-1:0]        mux_pix;
  logic [NUM_CH-1:1]       hits;
  logic [NUM_CH-1:1]       acc;

  frame_edge_counter #(.FC_W(FC_W)) u_frame_edge_counter (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_en      (pix_en),
    .vs_n        (vs_n),
    .frame_edge  (frame_edge),
    .frame_count (frame_count)
  );

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      opaque[i] = ch_on[i] & (ch_pixel[i*PIX_W +: PIX_W] != TRANSPARENT)
                  & ~(ch_blink[i] & frame_count[BLINK_BIT]);
    end
  end

  // Scanning from the top down lets the lowest-numbered opaque channel win.
  always_comb begin
    mux_pix = s1_bg;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (s1_opaque[i]) mux_pix = s1_pix[i*PIX_W +: PIX_W];
    end
  end

  assign hits = s1_opaque[NUM_CH-1:1] & {(NUM_CH-1){s1_opaque[CH_PLAYER] & s1_blank_n}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_opaque   <= '0;
      s1_pix      <= '0;
      s1_bg       <= '0;
      s1_blank_n  <= 1'b0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      acc         <= '0;
      collide     <= '0;
    end else if (pix_en) begin
      s1_opaque   <= opaque;
      s1_pix      <= ch_pixel;
      s1_bg       <= bg_pixel;
      s1_blank_n  <= blank_n;
      pixel_out   <= s1_blank_n ? mux_pix : '0;
      pixel_valid <= s1_blank_n;
      // Hits retiring on the edge beat still belong to the frame that is ending.
      if (frame_edge) begin
        collide <= {acc | hits, 1'b0};
        acc     <= '0;
      end else begin
        acc <= acc | hits;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random strobes against a
// queue-based reference of the compositing, blink and collision rules.
module tb_sprite_compositor;

  localparam int NUM_CH    = 4;
  localparam int PIX_W     = 5;
  localparam int FC_W      = 7;
  localparam int BLINK_BIT = 3;
  localparam int EW        = NUM_CH + 1 + PIX_W;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    pix_en = 1'b0;
  logic                    blank_n = 1'b0;
  logic                    vs_n = 1'b1;
  logic [NUM_CH-1:0]       ch_on = '0;
  logic [NUM_CH*PIX_W-1:0] ch_pixel = '0;
  logic [NUM_CH-1:0]       ch_blink = '0;
  logic [PIX_W-1:0]        bg_pixel = '0;
  logic [PIX_W-1:0]        pixel_out;
  logic                    pixel_valid;
  logic [NUM_CH-1:0]       collide;
  logic [FC_W-1:0]         frame_count;

  sprite_compositor #(
    .NUM_CH(NUM_CH), .PIX_W(PIX_W), .TRANSPARENT('0), .BLINK_BIT(BLINK_BIT), .FC_W(FC_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .blank_n(blank_n), .vs_n(vs_n),
    .ch_on(ch_on), .ch_pixel(ch_pixel), .ch_blink(ch_blink), .bg_pixel(bg_pixel),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .collide(collide),
    .frame_count(frame_count)
  );

  // Clock / reset
  always #10 Clk = ~Clk;

  // Scoreboard state: exp_q holds {hits, valid, pixel} per strobed input.
  logic [EW-1:0]     exp_q[$];
  int                tests_run = 0;
  int                tests_failed = 0;
  int                m_fc;
  logic              m_vs_prev;
  logic [NUM_CH-1:0] m_acc;
  logic [NUM_CH-1:0] m_col;
  logic [PIX_W-1:0]  m_pix;
  logic              m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // What the current inputs should produce, given the frame number they arrive in.
  function automatic logic [EW-1:0] expect_of(input int fc);
    logic [NUM_CH-1:0] vis;
    logic [NUM_CH-1:0] hit;
    logic [PIX_W-1:0]  pix;
    int first;
    first = -1;
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      vis[i] = ch_on[i] && (ch_pixel[i*PIX_W +: PIX_W] != 0) && !(ch_blink[i] && ((fc >> BLINK_BIT) & 1) == 1);
      if (vis[i] && first < 0) first = i;
    end
    if (!blank_n) pix = '0;
    else if (first >= 0) pix = ch_pixel[first*PIX_W +: PIX_W];
    else pix = bg_pixel;
    if (blank_n && vis[0]) for (int i = 1; i < NUM_CH; i++) hit[i] = vis[i];
    return {hit, blank_n, pix};
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".pixel_out"}, 32'(pixel_out), 32'(m_pix));
    check({where, ".pixel_valid"}, 32'(pixel_valid), 32'(m_valid));
    check({where, ".collide"}, 32'(collide), 32'(m_col));
    check({where, ".frame_count"}, 32'(frame_count), 32'(m_fc));
  endtask

  // Driver tasks
  task automatic set_in(input int on, input int p0, input int p1, input int p2, input int p3,
                        input int blink, input int bg, input bit blank, input bit vs);
    ch_on    = NUM_CH'(on);
    ch_pixel = {PIX_W'(p3), PIX_W'(p2), PIX_W'(p1), PIX_W'(p0)};
    ch_blink = NUM_CH'(blink);
    bg_pixel = PIX_W'(bg);
    blank_n  = blank;
    vs_n     = vs;
  endtask

  task automatic step(input string where);
    logic [EW-1:0]     e;
    logic [NUM_CH-1:0] hits;
    exp_q.push_back(expect_of(m_fc));
    pix_en = 1'b1;
    @(posedge Clk);
    #1;
    pix_en = 1'b0;
    e = exp_q.pop_front();
    hits = e[EW-1 -: NUM_CH];
    m_pix = e[PIX_W-1:0];
    m_valid = e[PIX_W];
    if (!vs_n && m_vs_prev) begin
      m_col = m_acc | hits;
      m_acc = '0;
      m_fc  = (m_fc + 1) % (1 << FC_W);
    end else begin
      m_acc = m_acc | hits;
    end
    m_vs_prev = vs_n;
    check_outputs(where);
  endtask

  task automatic idle(input string where);
    @(posedge Clk);
    #1;
    check_outputs(where);
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    pix_en = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    pix_en = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    m_fc = 0; m_vs_prev = 1'b1; m_acc = '0; m_col = '0; m_pix = '0; m_valid = 1'b0;
    check_outputs("reset");
  endtask

  initial begin
    reset_dut();

    // Background only
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 1);
    step("bg1");
    step("bg2");
    check("bg_const", 32'(pixel_out), 32'd9);
    check("bg_valid_const", 32'(pixel_valid), 32'd1);
    step("bg3");

    // Priority and transparency
    set_in(4'b0110, 0, 7, 12, 0, 0, 9, 1, 1);
    step("prio1"); step("prio2");
    check("prio_const", 32'(pixel_out), 32'd7);
    set_in(4'b0110, 0, 0, 12, 0, 0, 9, 1, 1);
    step("transp1"); step("transp2");
    check("transp_const", 32'(pixel_out), 32'd12);

    // Collision over a frame edge, then a clean frame
    set_in(4'b0101, 3, 0, 4, 0, 0, 9, 1, 1);
    step("hit");
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 0);
    step("edge1");
    check("collide_const", 32'(collide), 32'b0100);
    check("fc1_const", 32'(frame_count), 32'd1);
    set_in(4'b0001, 3, 0, 4, 0, 0, 9, 1, 1);
    step("clean1"); step("clean2");
    idle("hold");
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 0);
    step("edge2");
    check("collide_clear_const", 32'(collide), 32'd0);
    check("fc2_const", 32'(frame_count), 32'd2);

    // Overlap only during blanking
    set_in(4'b0101, 3, 0, 4, 0, 0, 9, 0, 1);
    step("blank1"); step("blank2");
    check("blank_valid_const", 32'(pixel_valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 0);
    step("blank_edge");
    check("blank_collide_const", 32'(collide), 32'd0);

    // Blink across frames and frame counter wrap
    reset_dut();
    for (int f = 0; f < 128; f++) begin
      set_in(4'b0010, 0, 6, 0, 0, 4'b0010, 9, 1, 1);
      step("blink_a"); step("blink_b");
      if (f < 16) check("blink_const", 32'(pixel_out), (f < 8) ? 32'd6 : 32'd9);
      vs_n = 1'b0;
      step("blink_edge");
    end
    check("wrap_const", 32'(frame_count), 32'd0);

    // Hit retiring on the edge strobe, then reset discarding a partial frame
    reset_dut();
    set_in(4'b0011, 3, 5, 0, 0, 0, 9, 1, 1);
    step("edgehit_a");
    vs_n = 1'b0;
    step("edgehit_edge");
    check("edgehit_const", 32'(collide), 32'b0010);
    set_in(4'b0011, 3, 5, 0, 0, 0, 9, 1, 1);
    step("midreset_a"); step("midreset_b");
    reset_dut();
    set_in(0, 0, 0, 0, 0, 0, 9, 1, 1);
    step("midreset_c");
    vs_n = 1'b0;
    step("midreset_edge");
    check("midreset_const", 32'(collide), 32'd0);

    // Random strobes with idle gaps
    for (int n = 0; n < 1500; n++) begin
      set_in($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 15),
             $urandom_range(0, 31), $urandom_range(0, 4) != 0, $urandom_range(0, 7) != 0);
      step("rand");
      if ($urandom_range(0, 5) == 0) idle("rand_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
